// File: rtl/hadamard_frame_driver.sv
// Initiator side of the complex Hadamard engine: accepts a 4-lane sample group, fetches its
// twiddle group, pulses start, captures the result on done and streams it out, under a watchdog.
module hadamard_frame_driver #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 1 + expWidth + sigWidth,
    parameter int NUM_GROUPS  = 4,
    parameter int TW_ADDR_W   = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [formatWidth*4-1:0] in_real,
    input  logic [formatWidth*4-1:0] in_imag,
    output logic [TW_ADDR_W-1:0]     tw_addr,
    input  logic [formatWidth*4-1:0] tw_real,
    input  logic [formatWidth*4-1:0] tw_imag,
    output logic                     had_start,
    output logic [formatWidth*4-1:0] had_input_real,
    output logic [formatWidth*4-1:0] had_input_imag,
    output logic [formatWidth*4-1:0] had_twiddle_real,
    output logic [formatWidth*4-1:0] had_twiddle_imag,
    input  logic [formatWidth*4-1:0] had_output_real,
    input  logic [formatWidth*4-1:0] had_output_imag,
    input  logic                     had_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [formatWidth*4-1:0] out_real,
    output logic [formatWidth*4-1:0] out_imag,
    output logic                     out_last,
    output logic                     err
);
    localparam int GW   = formatWidth * 4;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW_ADDR_W-1:0] LAST_GROUP = TW_ADDR_W'(NUM_GROUPS - 1);
    localparam logic [WD_W-1:0]      WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_DONE,
        S_OUTPUT
    } state_e;

    state_e                 state_q, state_d;
    logic [TW_ADDR_W-1:0]   group_q, group_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   last_q, last_d;
    logic [GW-1:0]          in_re_q, in_re_d, in_im_q, in_im_d;
    logic [GW-1:0]          tw_re_q, tw_re_d, tw_im_q, tw_im_d;
    logic [GW-1:0]          out_re_q, out_re_d, out_im_q, out_im_d;

    logic accept, done_hit, wd_expired, out_fire;

    assign accept     = (state_q == S_IDLE) && in_valid;
    assign done_hit   = (state_q == S_WAIT_DONE) && had_done;
    // A done on the expiry cycle takes priority, so expiry requires the absence of done.
    assign wd_expired = (state_q == S_WAIT_DONE) && !had_done && (wd_q == WD_LAST);
    assign out_fire   = (state_q == S_OUTPUT) && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (accept) state_d = S_FETCH;
            S_FETCH:     state_d = S_START;
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (done_hit)        state_d = S_OUTPUT;
                else if (wd_expired) state_d = S_IDLE;
            end
            S_OUTPUT:    if (out_fire) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUTPUT);
    end

    always_comb begin
        group_d  = group_q;
        wd_d     = wd_q;
        err_d    = err_q;
        last_d   = last_q;
        in_re_d  = in_re_q;
        in_im_d  = in_im_q;
        tw_re_d  = tw_re_q;
        tw_im_d  = tw_im_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        start_d  = (state_q == S_FETCH);

        if (accept) begin
            in_re_d = in_real;
            in_im_d = in_imag;
        end
        if (state_q == S_FETCH) begin
            tw_re_d = tw_real;
            tw_im_d = tw_imag;
        end
        if (state_q == S_START) wd_d = '0;
        if ((state_q == S_WAIT_DONE) && !had_done && !wd_expired) wd_d = wd_q + 1'b1;
        if (done_hit) begin
            out_re_d = had_output_real;
            out_im_d = had_output_imag;
            last_d   = (group_q == LAST_GROUP);
        end
        if (wd_expired) begin
            err_d   = 1'b1;
            group_d = '0;
        end
        if (out_fire) group_d = (group_q == LAST_GROUP) ? '0 : group_q + 1'b1;
    end

    // NOTE: the operand and result registers are plain flops, so they take the reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            group_q  <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            in_re_q  <= '0;
            in_im_q  <= '0;
            tw_re_q  <= '0;
            tw_im_q  <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            group_q  <= group_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            start_q  <= start_d;
            last_q   <= last_d;
            in_re_q  <= in_re_d;
            in_im_q  <= in_im_d;
            tw_re_q  <= tw_re_d;
            tw_im_q  <= tw_im_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign tw_addr          = group_q;
    assign had_start        = start_q;
    assign had_input_real   = in_re_q;
    assign had_input_imag   = in_im_q;
    assign had_twiddle_real = tw_re_q;
    assign had_twiddle_imag = tw_im_q;
    assign out_real         = out_re_q;
    assign out_imag         = out_im_q;
    assign out_last         = last_q;
    assign err              = err_q;

endmodule

// File: doc/hadamard_frame_driver.md
Name: hadamard_frame_driver

Overview:
- Initiator side of the complex Hadamard engine's start/done handshake.
- Accepts 4-lane SFP sample groups over a valid/ready stream and fetches the matching 4-lane twiddle group from an external twiddle ROM.
- Drives the engine with stable operands and a one-cycle start pulse, then captures the result on done and presents it on a valid/ready output stream.
- Sits between the sample buffer and the engine in the FFT datapath. Also sequences twiddle addresses across a frame and supervises the engine with a watchdog.

Parameters:
- expWidth, 4, SFP exponent width (passed through only; no arithmetic on it).
- sigWidth, 4, SFP mantissa width (passed through only).
- formatWidth, 9, width of one SFP word (sign + exponent + mantissa).
- NUM_GROUPS, 4, number of 4-lane groups per frame; also the twiddle ROM depth.
- TW_ADDR_W, 2, twiddle ROM address width; must satisfy 2**TW_ADDR_W >= NUM_GROUPS.
- TIMEOUT, 32, maximum number of WAIT_DONE cycles before the engine is declared hung.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input group valid.
- in_ready  out  1  block can accept a group.
- in_real  in  formatWidth*4  lanes 0..3 real parts; lane k at [formatWidth*(k+1)-1 : formatWidth*k].
- in_imag  in  formatWidth*4  lanes 0..3 imaginary parts; same packing.
- tw_addr  out  TW_ADDR_W  twiddle ROM address.
- tw_real  in  formatWidth*4  ROM read data, real; 1-cycle read latency.
- tw_imag  in  formatWidth*4  ROM read data, imaginary; 1-cycle read latency.
- had_start  out  1  engine start pulse.
- had_input_real  out  formatWidth*4  engine operand.
- had_input_imag  out  formatWidth*4  engine operand.
- had_twiddle_real  out  formatWidth*4  engine operand.
- had_twiddle_imag  out  formatWidth*4  engine operand.
- had_output_real  in  formatWidth*4  engine result.
- had_output_imag  in  formatWidth*4  engine result.
- had_done  in  1  engine result valid.
- out_valid  out  1  result group valid.
- out_ready  in  1  downstream accepts.
- out_real  out  formatWidth*4  result group, real.
- out_imag  out  formatWidth*4  result group, imaginary.
- out_last  out  1  result is the last group of the frame.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE, group counter to 0, watchdog counter to 0.
  - All operand, twiddle and result registers clear to 0.
  - had_start=0, out_valid=0, out_last=0, err=0.
  - A reset mid-operation abandons any in-flight group. A had_done arriving after reset in IDLE is ignored.
- tw_addr = group counter (registered) at all times. Because the address is stable during IDLE, ROM data is valid by FETCH.
- in_ready = 1 only in IDLE. The combinational in_ready depends on state only, never on in_valid.
- State machine:
  - IDLE: on in_valid && in_ready, register in_real/in_imag into the operand registers, then go to FETCH.
  - FETCH (1 cycle): register tw_real/tw_imag, then go to START.
  - START (1 cycle): had_start=1 (registered output, high exactly this cycle). Clear the watchdog, then go to WAIT_DONE.
  - WAIT_DONE:
    - had_done=1: register had_output_real/imag into the out registers, set out_last = (group == NUM_GROUPS-1), go to OUTPUT.
    - Otherwise the watchdog increments. When the watchdog reaches TIMEOUT-1 with no done: set err=1, reset group to 0, go to IDLE. No output is produced for that group.
  - OUTPUT: out_valid=1. On out_ready:
    - Group increments, wrapping from NUM_GROUPS-1 to 0.
    - out_valid drops next cycle; go to IDLE.
- Operand stability: had_input_* and had_twiddle_* are driven from registers and are unchanged from FETCH exit until the next IDLE accept.
- had_done in any state other than WAIT_DONE is ignored.
- had_done on the same cycle the watchdog expires: done wins; err is not set.
- Output-stream rules:
  - out_real, out_imag and out_last hold stable while out_valid=1 && !out_ready.
  - out_valid never drops without a handshake, except on rst.
- Throughput: at most one group in flight. Minimum group period = 5 cycles + engine latency.
- err stays high until rst.
- No arithmetic on SFP fields: data is passed through bit-exact, with no lane reordering.

Test Plan:
- Single group: in_real lanes = 9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, group 0.
  - tw_addr must be 0 and had_twiddle_* must equal ROM[0].
  - had_start must be high for exactly 1 cycle, 2 cycles after the accept.
  - A stub engine returning 9'h155 on all lanes after 6 cycles must yield out_real = {4{9'h155}}, out_last=0.
- Full frame of NUM_GROUPS=4 back-to-back groups:
  - tw_addr must sequence 0,1,2,3, then wrap to 0.
  - out_last=1 only on the 4th output.
  - in_ready must be 0 from accept until output handshake.
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_valid must stay 1 with data stable.
  - in_ready must stay 0.
  - Release: handshake completes and in_ready rises the next cycle.
- Watchdog: the stub never asserts had_done.
  - After TIMEOUT=32 WAIT_DONE cycles: err=1, back to IDLE, group reset to 0, no out_valid.
  - The next accepted group uses tw_addr=0.
- Done on the expiry cycle: result is captured, err stays 0. A stray had_done pulse in IDLE has no effect.
- Reset in WAIT_DONE and in OUTPUT: next cycle out_valid=0, had_start=0, in_ready=1, tw_addr=0.
